// File: rtl/mc_controller.sv
// Multi-cycle MIPS sequencer: FETCH/DECODE/EXEC/MEM/WB with combinational control decode.
// Latency 2-5 cycles per instruction; FETCH and MEM hold their request until MemAck.
module mc_controller (
   input  logic        CLK,
   input  logic        RST,
   input  logic [5:0]  Opcode,
   input  logic [5:0]  Funct,
   input  logic        Zero,
   input  logic        MemAck,
   output logic        MemReq,
   output logic        MemWe,
   output logic        IorD,
   output logic        IRWrite,
   output logic        PCWrite,
   output logic [1:0]  PCSrc,
   output logic        RegWrite,
   output logic [1:0]  RegDst,
   output logic [1:0]  MemToReg,
   output logic [1:0]  ALUSrcB,
   output logic [1:0]  ALUOp,
   output logic [2:0]  State,
   output logic [31:0] InsCount
);

   localparam logic [5:0] OP_R   = 6'h00;
   localparam logic [5:0] OP_J   = 6'h02;
   localparam logic [5:0] OP_JAL = 6'h03;
   localparam logic [5:0] OP_BEQ = 6'h04;
   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_SW  = 6'h2B;
   localparam logic [5:0] FN_JR  = 6'h08;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4
   } state_t;

   state_t      state;
   logic [31:0] ins_count;

   logic is_r, is_jr, is_lw, is_sw, is_beq, is_jump;
   assign is_r    = (Opcode == OP_R);
   assign is_jr   = is_r && (Funct == FN_JR);
   assign is_lw   = (Opcode == OP_LW);
   assign is_sw   = (Opcode == OP_SW);
   assign is_beq  = (Opcode == OP_BEQ);
   assign is_jump = (Opcode == OP_J) || (Opcode == OP_JAL) || is_jr;

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state     <= S_FETCH;
         ins_count <= 32'd0;
      end else begin
         case (state)
            S_FETCH:  if (MemAck) state <= S_DECODE;
            S_DECODE: begin
               if (is_jump) begin
                  state     <= S_FETCH;
                  ins_count <= ins_count + 32'd1;
               end else begin
                  state <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (is_beq) begin
                  state     <= S_FETCH;
                  ins_count <= ins_count + 32'd1;
               end else if (is_lw || is_sw) begin
                  state <= S_MEM;
               end else begin
                  state <= S_WB;
               end
            end
            S_MEM: begin
               // Only loads and stores reach MEM, so a non-store is a load.
               if (MemAck) begin
                  if (is_sw) begin
                     state     <= S_FETCH;
                     ins_count <= ins_count + 32'd1;
                  end else begin
                     state <= S_WB;
                  end
               end
            end
            S_WB: begin
               state     <= S_FETCH;
               ins_count <= ins_count + 32'd1;
            end
            default: state <= S_FETCH;
         endcase
      end
   end

   always_comb begin
      MemReq   = 1'b0;
      MemWe    = 1'b0;
      IorD     = 1'b0;
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      PCSrc    = 2'd0;
      RegWrite = 1'b0;
      RegDst   = 2'd0;
      MemToReg = 2'd0;
      ALUSrcB  = 2'd0;
      ALUOp    = 2'd0;
      State    = 3'd0;
      InsCount = 32'd0;
      // Reset is sampled synchronously but still silences every output while low.
      if (RST) begin
         State    = state;
         InsCount = ins_count;
         case (state)
            S_FETCH: begin
               MemReq = 1'b1;
               if (MemAck) begin
                  IRWrite = 1'b1;
                  PCWrite = 1'b1;
                  ALUSrcB = 2'd1;
               end
            end
            S_DECODE: begin
               ALUSrcB = 2'd2;
               if (Opcode == OP_J || Opcode == OP_JAL) begin
                  PCWrite = 1'b1;
                  PCSrc   = 2'd2;
               end
               if (Opcode == OP_JAL) begin
                  RegWrite = 1'b1;
                  RegDst   = 2'd2;
                  MemToReg = 2'd2;
               end
               if (is_jr) begin
                  PCWrite = 1'b1;
                  PCSrc   = 2'd3;
               end
            end
            S_EXEC: begin
               if (is_beq) begin
                  ALUOp   = 2'd1;
                  PCSrc   = 2'd1;
                  PCWrite = Zero;
               end else if (is_r) begin
                  ALUOp = 2'd2;
               end else begin
                  ALUSrcB = 2'd2;
               end
            end
            S_MEM: begin
               MemReq = 1'b1;
               IorD   = 1'b1;
               MemWe  = is_sw;
            end
            S_WB: begin
               RegWrite = 1'b1;
               MemToReg = is_lw ? 2'd1 : 2'd0;
               RegDst   = is_r ? 2'd1 : 2'd0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mc_controller.sv
// Directed vector bench for mc_controller: one table row per clock cycle, plus a jump sequence with fetch stalls.
module tb_mc_controller;

   localparam logic [5:0] OP_R   = 6'h00;
   localparam logic [5:0] OP_J   = 6'h02;
   localparam logic [5:0] OP_JAL = 6'h03;
   localparam logic [5:0] OP_BEQ = 6'h04;
   localparam logic [5:0] OP_ADI = 6'h08;
   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_SW  = 6'h2B;
   localparam logic [5:0] FN_JR  = 6'h08;
   localparam logic [5:0] FN_ADD = 6'h20;

   logic        CLK = 1'b0;
   logic        RST;
   logic [5:0]  Opcode, Funct;
   logic        Zero, MemAck;
   logic        MemReq, MemWe, IorD, IRWrite, PCWrite, RegWrite;
   logic [1:0]  PCSrc, RegDst, MemToReg, ALUSrcB, ALUOp;
   logic [2:0]  State;
   logic [31:0] InsCount;

   always #5 CLK = ~CLK;

   mc_controller dut (
      .CLK(CLK), .RST(RST), .Opcode(Opcode), .Funct(Funct), .Zero(Zero), .MemAck(MemAck),
      .MemReq(MemReq), .MemWe(MemWe), .IorD(IorD), .IRWrite(IRWrite), .PCWrite(PCWrite),
      .PCSrc(PCSrc), .RegWrite(RegWrite), .RegDst(RegDst), .MemToReg(MemToReg),
      .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .State(State), .InsCount(InsCount)
   );

   typedef struct packed {
      logic [2:0]  st;
      logic        req, we, iord, irw, pcw;
      logic [1:0]  pcsrc;
      logic        rw;
      logic [1:0]  rdst, m2r, srcb, aop;
      logic [31:0] cnt;
   } out_t;

   typedef struct {
      logic       rst;
      logic [5:0] op, fn;
      logic       zero, ack;
      out_t       exp;
      string      name;
   } vec_t;

   vec_t vq[$];
   out_t act;
   int   n_chk = 0;
   int   n_fail = 0;

   always_comb act = {State, MemReq, MemWe, IorD, IRWrite, PCWrite, PCSrc, RegWrite,
                      RegDst, MemToReg, ALUSrcB, ALUOp, InsCount};

   function automatic out_t o(input logic [2:0] st, input logic req, we, iord, irw, pcw,
                              input logic [1:0] pcsrc, input logic rw,
                              input logic [1:0] rdst, m2r, srcb, aop, input logic [31:0] cnt);
      return {st, req, we, iord, irw, pcw, pcsrc, rw, rdst, m2r, srcb, aop, cnt};
   endfunction

   function automatic out_t fa(input logic [31:0] c); return o(0,1,0,0,1,1,0,0,0,0,1,0,c); endfunction
   function automatic out_t fw(input logic [31:0] c); return o(0,1,0,0,0,0,0,0,0,0,0,0,c); endfunction
   function automatic out_t dc(input logic [31:0] c); return o(1,0,0,0,0,0,0,0,0,0,2,0,c); endfunction
   function automatic out_t ei(input logic [31:0] c); return o(2,0,0,0,0,0,0,0,0,0,2,0,c); endfunction

   task automatic add(input logic rst, input logic [5:0] op, fn, input logic zero, ack,
                      input out_t exp, input string name);
      vec_t v;
      v.rst = rst; v.op = op; v.fn = fn; v.zero = zero; v.ack = ack; v.exp = exp; v.name = name;
      vq.push_back(v);
   endtask

   task automatic chk(input string name, input logic [63:0] a, input logic [63:0] e);
      n_chk++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, a, e);
      end
   endtask

   task automatic step(input logic rst, input logic [5:0] op, fn, input logic zero, ack);
      @(posedge CLK);
      #1;
      RST = rst; Opcode = op; Funct = fn; Zero = zero; MemAck = ack;
      @(negedge CLK);
   endtask

   logic [31:0] expcnt;

   initial begin
      RST = 1'b0; Opcode = OP_LW; Funct = 6'h0; Zero = 1'b0; MemAck = 1'b1;

      for (int i = 0; i < 3; i++) add(0, OP_LW, 0, 0, 1, o(0,0,0,0,0,0,0,0,0,0,0,0,0), "reset");
      // LW, ack always 1
      add(1, OP_LW, 0, 0, 1, fa(0), "lw fetch");
      add(1, OP_LW, 0, 0, 1, dc(0), "lw decode");
      add(1, OP_LW, 0, 0, 1, ei(0), "lw exec");
      add(1, OP_LW, 0, 0, 1, o(3,1,0,1,0,0,0,0,0,0,0,0,0), "lw mem");
      add(1, OP_LW, 0, 0, 1, o(4,0,0,0,0,0,0,1,0,1,0,0,0), "lw wb");
      // SW with three wait cycles in MEM
      add(1, OP_SW, 0, 0, 1, fa(1), "sw fetch");
      add(1, OP_SW, 0, 0, 0, dc(1), "sw decode");
      add(1, OP_SW, 0, 0, 0, ei(1), "sw exec");
      for (int i = 0; i < 3; i++) add(1, OP_SW, 0, 0, 0, o(3,1,1,1,0,0,0,0,0,0,0,0,1), "sw mem wait");
      add(1, OP_SW, 0, 0, 1, o(3,1,1,1,0,0,0,0,0,0,0,0,1), "sw mem ack");
      // BEQ taken, then not taken
      add(1, OP_BEQ, 0, 1, 1, fa(2), "beq1 fetch");
      add(1, OP_BEQ, 0, 1, 1, dc(2), "beq1 decode");
      add(1, OP_BEQ, 0, 1, 1, o(2,0,0,0,0,1,1,0,0,0,0,1,2), "beq1 exec taken");
      add(1, OP_BEQ, 0, 0, 1, fa(3), "beq2 fetch");
      add(1, OP_BEQ, 0, 0, 1, dc(3), "beq2 decode");
      add(1, OP_BEQ, 0, 0, 1, o(2,0,0,0,0,0,1,0,0,0,0,1,3), "beq2 exec not taken");
      // JAL, JR, ADD
      add(1, OP_JAL, 0, 0, 1, fa(4), "jal fetch");
      add(1, OP_JAL, 0, 0, 1, o(1,0,0,0,0,1,2,1,2,2,2,0,4), "jal decode");
      add(1, OP_R, FN_JR, 0, 1, fa(5), "jr fetch");
      add(1, OP_R, FN_JR, 0, 1, o(1,0,0,0,0,1,3,0,0,0,2,0,5), "jr decode");
      add(1, OP_R, FN_ADD, 0, 1, fa(6), "add fetch");
      add(1, OP_R, FN_ADD, 0, 1, dc(6), "add decode");
      add(1, OP_R, FN_ADD, 0, 1, o(2,0,0,0,0,0,0,0,0,0,0,2,6), "add exec");
      add(1, OP_R, FN_ADD, 0, 1, o(4,0,0,0,0,0,0,1,1,0,0,0,6), "add wb");
      add(1, OP_LW, 0, 0, 0, fw(7), "fetch stall");
      // LW abandoned by reset while MEM waits
      add(1, OP_LW, 0, 0, 1, fa(7), "lw2 fetch");
      add(1, OP_LW, 0, 0, 0, dc(7), "lw2 decode");
      add(1, OP_LW, 0, 0, 0, ei(7), "lw2 exec");
      add(1, OP_LW, 0, 0, 0, o(3,1,0,1,0,0,0,0,0,0,0,0,7), "lw2 mem wait");
      add(0, OP_LW, 0, 0, 0, o(0,0,0,0,0,0,0,0,0,0,0,0,0), "reset in mem");
      add(1, OP_LW, 0, 0, 0, fw(0), "after mem reset");
      // I-form ALU op
      add(1, OP_ADI, 0, 0, 1, fa(0), "addi fetch");
      add(1, OP_ADI, 0, 0, 1, dc(0), "addi decode");
      add(1, OP_ADI, 0, 0, 1, ei(0), "addi exec");
      add(1, OP_ADI, 0, 0, 1, o(4,0,0,0,0,0,0,1,0,0,0,0,0), "addi wb");
      add(1, OP_ADI, 0, 0, 0, fw(1), "addi retired");

      foreach (vq[i]) begin
         step(vq[i].rst, vq[i].op, vq[i].fn, vq[i].zero, vq[i].ack);
         chk(vq[i].name, 64'(act), 64'(vq[i].exp));
      end

      // J with 0..2 fetch stalls: FETCH waits, DECODE jumps, then back to FETCH with one more retired
      expcnt = 32'd1;
      for (int w = 0; w < 3; w++) begin
         for (int k = 0; k < w; k++) begin
            step(1, OP_J, 0, 0, 0);
            chk("j stall", {61'd0, State}, {61'd0, 3'd0});
            chk("j stall req", {63'd0, MemReq}, 64'd1);
         end
         step(1, OP_J, 0, 0, 1);
         chk("j fetch ack", 64'(act), 64'(fa(expcnt)));
         step(1, OP_J, 0, 0, 0);
         chk("j decode", 64'(act), 64'(o(1,0,0,0,0,1,2,0,0,0,2,0,expcnt)));
         expcnt = expcnt + 32'd1;
         step(1, OP_J, 0, 0, 0);
         chk("j back to fetch", 64'(act), 64'(fw(expcnt)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
